// File: rtl/xor_err_accum_if.sv
// Handshake bundle for the BER error accumulator: word input side and
// per-frame result side.
interface xor_err_accum_if #(
    parameter int N  = 16,
    parameter int CW = 32,
    parameter int WW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_diff;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_errs;
    logic [WW-1:0] out_words;
    logic          out_sat;

    modport master (
        output in_valid, in_diff, in_last, out_ready,
        input  in_ready, out_valid, out_errs, out_words, out_sat
    );

    modport slave (
        input  in_valid, in_diff, in_last, out_ready,
        output in_ready, out_valid, out_errs, out_words, out_sat
    );
endinterface

// File: rtl/xor_err_accum.sv
// Per-frame bit-error accumulator: popcount stage, then saturating
// frame accumulation with a held valid/ready result.
module xor_err_accum #(
    parameter int N  = 16,
    parameter int CW = 32,
    parameter int WW = 16
) (
    input logic           clk,
    input logic           rst,
    xor_err_accum_if.slave bus
);
    localparam int PW = $clog2(N + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic [CW-1:0] E_MAX = '1;
    localparam logic [WW-1:0] W_MAX = '1;

    logic          adv;
    logic          accepted;
    logic [PW-1:0] pop;

    logic          s1_v;
    logic          s1_last;
    logic [PW-1:0] s1_cnt;

    logic [CW-1:0] acc;
    logic [WW-1:0] wcnt;
    logic          sat;

    logic          o_valid;
    logic [CW-1:0] o_errs;
    logic [WW-1:0] o_words;
    logic          o_sat;

    logic [SW-1:0] e_sum;
    logic          e_clamp;
    logic [CW-1:0] e;
    logic [WW:0]   w_sum;
    logic          w_clamp;
    logic [WW-1:0] w;

    // Whole pipeline stalls while a result waits for downstream.
    assign adv      = !o_valid || bus.out_ready;
    assign accepted = bus.in_valid && adv;

    assign bus.in_ready  = adv;
    assign bus.out_valid = o_valid;
    assign bus.out_errs  = o_errs;
    assign bus.out_words = o_words;
    assign bus.out_sat   = o_sat;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(bus.in_diff[i]);
        end
    end

    always_comb begin
        e_sum   = SW'(acc) + SW'(s1_cnt);
        e_clamp = e_sum > SW'(E_MAX);
        e       = e_clamp ? E_MAX : e_sum[CW-1:0];
        w_sum   = {1'b0, wcnt} + (WW+1)'(1);
        w_clamp = w_sum[WW];
        w       = w_clamp ? W_MAX : w_sum[WW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_cnt  <= '0;
            acc     <= '0;
            wcnt    <= '0;
            sat     <= 1'b0;
            o_valid <= 1'b0;
            o_errs  <= '0;
            o_words <= '0;
            o_sat   <= 1'b0;
        end else begin
            if (o_valid && bus.out_ready) begin
                o_valid <= 1'b0;
            end
            if (adv) begin
                s1_v    <= accepted;
                s1_cnt  <= pop;
                s1_last <= bus.in_last;
                if (s1_v) begin
                    if (s1_last) begin
                        // A result loaded here overrides the clear above.
                        o_errs  <= e;
                        o_words <= w;
                        o_sat   <= sat | e_clamp | w_clamp;
                        o_valid <= 1'b1;
                        acc     <= '0;
                        wcnt    <= '0;
                        sat     <= 1'b0;
                    end else begin
                        acc <= e;
                        wcnt <= w;
                        sat  <= sat | e_clamp | w_clamp;
                    end
                end
            end
        end
    end
endmodule
